// File: rtl/frame_scheduler_pkg.sv
// Shared constants and state encoding for the correlator frame scheduler.
package frame_scheduler_pkg;

    localparam int DEF_NUM_INPUTS = 8;
    localparam int DEF_LAG_W      = 20;
    localparam int DEF_INC_W      = 12;
    localparam int DEF_FRAME_W    = 24;
    localparam int FRAME_COUNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_INTEGRATE = 3'd2,
        ST_WAIT_TX   = 3'd3,
        ST_LATCH     = 3'd4,
        ST_SEND      = 3'd5,
        ST_STEP      = 3'd6
    } sched_state_t;

endpackage

// File: rtl/frame_scheduler_if.sv
// Host/packet-generator side signal bundle of the frame scheduler.
interface frame_scheduler_if
    import frame_scheduler_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int LAG_W      = DEF_LAG_W,
    parameter int INC_W      = DEF_INC_W,
    parameter int FRAME_W    = DEF_FRAME_W
);

    logic                          enable;
    logic                          integrate;
    logic [FRAME_W-1:0]            frame_ticks;
    logic [NUM_INPUTS-1:0]         scan_en;
    logic [NUM_INPUTS*LAG_W-1:0]   start_a;
    logic [NUM_INPUTS*LAG_W-1:0]   len_a;
    logic [NUM_INPUTS*INC_W-1:0]   inc_a;
    logic                          tx_busy;
    logic                          tx_done;

    logic [NUM_INPUTS*LAG_W-1:0]   current_a;
    logic                          capture;
    logic                          clear;
    logic                          latch;
    logic [FRAME_COUNT_W-1:0]      frame_count;
    logic                          scan_done;

    modport slave (
        input  enable, integrate, frame_ticks, scan_en, start_a, len_a, inc_a,
               tx_busy, tx_done,
        output current_a, capture, clear, latch, frame_count, scan_done
    );

    modport master (
        output enable, integrate, frame_ticks, scan_en, start_a, len_a, inc_a,
               tx_busy, tx_done,
        input  current_a, capture, clear, latch, frame_count, scan_done
    );

endinterface

// File: rtl/frame_scheduler_lag_stepper.sv
// One correlator input's lag sweep: holds the active lag and its done flag.
// A step advances the lag by inc only while the new value stays inside
// [start, start+len) and fits in LAG_W bits; otherwise the lane is done.
module lag_stepper
    import frame_scheduler_pkg::*;
#(
    parameter int LAG_W = DEF_LAG_W,
    parameter int INC_W = DEF_INC_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             scan_en_i,
    input  logic [LAG_W-1:0] start_i,
    input  logic [LAG_W-1:0] len_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [LAG_W-1:0] current_o,
    output logic             done_step_o
);

    logic [LAG_W-1:0] current_q, current_d;
    logic             done_q, done_d;
    logic [LAG_W:0]   next_sum;
    logic [LAG_W:0]   limit;
    logic             advance;

    // Candidate lag and sweep bound, both one bit wider so nothing wraps.
    always_comb begin
        next_sum = {1'b0, current_q} + (LAG_W+1)'(inc_i);
        limit    = {1'b0, start_i} + {1'b0, len_i};
        advance  = scan_en_i && (inc_i != '0) && !next_sum[LAG_W]
                   && (next_sum < limit);
    end

    // Next lag/done: reload on frame-sequence start, advance or finish on step.
    always_comb begin
        current_d = current_q;
        done_d    = done_q;
        if (load_i) begin
            current_d = start_i;
            done_d    = 1'b0;
        end else if (step_i && !done_q) begin
            if (advance) begin
                current_d = next_sum[LAG_W-1:0];
            end else begin
                done_d = 1'b1;
            end
        end
    end

    // Lag and done registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            current_q <= '0;
            done_q    <= 1'b0;
        end else begin
            current_q <= current_d;
            done_q    <= done_d;
        end
    end

    assign current_o   = current_q;
    // Done value this lane will hold after a step; feeds scan_done directly.
    assign done_step_o = done_q || !advance;

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: sequences clear/integrate/latch/send per frame and sweeps
// per-input correlator lags between frames.
//
// state        | meaning
// IDLE         | waiting for enable & integrate; lags reload on exit
// CLEAR        | one-cycle correlator clear pulse, tick counter zeroed
// INTEGRATE    | capture window, frame_ticks cycles (0 behaves as 1)
// WAIT_TX      | window closed, waiting for packet generator to go idle
// LATCH        | one-cycle payload snapshot pulse
// SEND         | waiting for tx_done from packet generator
// STEP         | advance lags, count frame, then continue or go idle
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int LAG_W      = DEF_LAG_W,
    parameter int INC_W      = DEF_INC_W,
    parameter int FRAME_W    = DEF_FRAME_W,
    parameter logic [FRAME_COUNT_W-1:0] FRAME_COUNT_RST = '0
) (
    input  logic              pllclk,
    input  logic              reset_n,
    frame_scheduler_if.slave  bus
);

    sched_state_t               state_q;
    logic [FRAME_W-1:0]         tick_q;
    logic [FRAME_W-1:0]         tick_last;
    logic                       capture_q;
    logic                       clear_q;
    logic                       latch_q;
    logic                       scan_done_q;
    logic [FRAME_COUNT_W-1:0]   frame_count_q;

    logic                       load_fire;
    logic                       step_fire;
    logic [NUM_INPUTS-1:0]      done_step;
    logic [NUM_INPUTS*LAG_W-1:0] current_vec;

    // Last tick index of the capture window; a zero length still captures once.
    always_comb begin
        tick_last = '0;
        if (bus.frame_ticks != '0) begin
            tick_last = bus.frame_ticks - FRAME_W'(1);
        end
    end

    assign load_fire = (state_q == ST_IDLE) && bus.enable && bus.integrate;
    assign step_fire = (state_q == ST_STEP) && bus.enable;

    // Sequencer with registered pulse/window outputs; enable low forces IDLE
    // but leaves lags, frame count and scan_done untouched.
    always_ff @(posedge pllclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            tick_q        <= '0;
            capture_q     <= 1'b0;
            clear_q       <= 1'b0;
            latch_q       <= 1'b0;
            scan_done_q   <= 1'b0;
            frame_count_q <= FRAME_COUNT_RST;
        end else if (!bus.enable) begin
            state_q   <= ST_IDLE;
            capture_q <= 1'b0;
            clear_q   <= 1'b0;
            latch_q   <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            latch_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.integrate) begin
                        state_q     <= ST_CLEAR;
                        clear_q     <= 1'b1;
                        scan_done_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    tick_q    <= '0;
                    state_q   <= ST_INTEGRATE;
                    capture_q <= 1'b1;
                end
                ST_INTEGRATE: begin
                    tick_q <= tick_q + FRAME_W'(1);
                    if (tick_q == tick_last) begin
                        state_q   <= ST_WAIT_TX;
                        capture_q <= 1'b0;
                    end
                end
                ST_WAIT_TX: begin
                    if (!bus.tx_busy) begin
                        state_q <= ST_LATCH;
                        latch_q <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.tx_done) begin
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    frame_count_q <= frame_count_q + FRAME_COUNT_W'(1);
                    scan_done_q   <= &done_step;
                    if (bus.integrate) begin
                        state_q <= ST_CLEAR;
                        clear_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    capture_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar a = 0; a < NUM_INPUTS; a++) begin : g_lane
        lag_stepper #(
            .LAG_W (LAG_W),
            .INC_W (INC_W)
        ) u_lag (
            .clk_i       (pllclk),
            .rst_n_i     (reset_n),
            .load_i      (load_fire),
            .step_i      (step_fire),
            .scan_en_i   (bus.scan_en[a]),
            .start_i     (bus.start_a[a*LAG_W +: LAG_W]),
            .len_i       (bus.len_a[a*LAG_W +: LAG_W]),
            .inc_i       (bus.inc_a[a*INC_W +: INC_W]),
            .current_o   (current_vec[a*LAG_W +: LAG_W]),
            .done_step_o (done_step[a])
        );
    end

    assign bus.current_a   = current_vec;
    assign bus.capture     = capture_q;
    assign bus.clear       = clear_q;
    assign bus.latch       = latch_q;
    assign bus.frame_count = frame_count_q;
    assign bus.scan_done   = scan_done_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: frame-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_frame_scheduler;
    import frame_scheduler_pkg::*;

    localparam int N  = 8;
    localparam int LW = 20;
    localparam int IW = 12;
    localparam int FW = 24;

    localparam int P_IDLE = 0, P_CLEAR = 1, P_CAP = 2, P_WAIT = 3,
                   P_LATCH = 4, P_SEND = 5, P_STEP = 6;

    logic pllclk  = 1'b0;
    logic reset_n = 1'b1;
    always #5 pllclk = ~pllclk;

    frame_scheduler_if #(.NUM_INPUTS(N), .LAG_W(LW), .INC_W(IW), .FRAME_W(FW)) m_if ();
    frame_scheduler_if #(.NUM_INPUTS(1), .LAG_W(LW), .INC_W(IW), .FRAME_W(FW)) w_if ();

    frame_scheduler #(.NUM_INPUTS(N), .LAG_W(LW), .INC_W(IW), .FRAME_W(FW)) dut (
        .pllclk (pllclk), .reset_n (reset_n), .bus (m_if)
    );

    frame_scheduler #(.NUM_INPUTS(1), .LAG_W(LW), .INC_W(IW), .FRAME_W(FW),
                      .FRAME_COUNT_RST(16'hFFF8)) dut_wrap (
        .pllclk (pllclk), .reset_n (reset_n), .bus (w_if)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int     ph = P_IDLE;
    int     cap_left = 0;
    longint cur [N];
    bit     dn  [N];
    int     fc = 0;
    bit     sdone = 1'b0;
    int     cap_cnt = 0, clr_cnt = 0, lat_cnt = 0;

    function automatic longint lane_start(int a);
        return longint'(m_if.start_a[a*LW +: LW]);
    endfunction
    function automatic longint lane_len(int a);
        return longint'(m_if.len_a[a*LW +: LW]);
    endfunction
    function automatic longint lane_inc(int a);
        return longint'(m_if.inc_a[a*IW +: IW]);
    endfunction

    task automatic model_reset();
        ph = P_IDLE; cap_left = 0; fc = 0; sdone = 1'b0;
        for (int a = 0; a < N; a++) begin
            cur[a] = 0;
            dn[a]  = 1'b0;
        end
    endtask

    task automatic model_advance();
        if (!m_if.enable) begin
            ph = P_IDLE;
            return;
        end
        case (ph)
            P_IDLE: if (m_if.integrate) begin
                for (int a = 0; a < N; a++) begin
                    cur[a] = lane_start(a);
                    dn[a]  = 1'b0;
                end
                sdone = 1'b0;
                ph = P_CLEAR;
            end
            P_CLEAR: begin
                cap_left = (m_if.frame_ticks == 0) ? 1 : int'(m_if.frame_ticks);
                ph = P_CAP;
            end
            P_CAP: begin
                cap_left--;
                if (cap_left == 0) ph = P_WAIT;
            end
            P_WAIT:  if (!m_if.tx_busy) ph = P_LATCH;
            P_LATCH: ph = P_SEND;
            P_SEND:  if (m_if.tx_done) ph = P_STEP;
            P_STEP: begin
                sdone = 1'b1;
                for (int a = 0; a < N; a++) begin
                    longint nxt;
                    nxt = cur[a] + lane_inc(a);
                    if (!dn[a]) begin
                        if (m_if.scan_en[a] && lane_inc(a) != 0 &&
                            nxt < lane_start(a) + lane_len(a) && nxt < (64'd1 << LW))
                            cur[a] = nxt;
                        else
                            dn[a] = 1'b1;
                    end
                    if (!dn[a]) sdone = 1'b0;
                end
                fc = (fc + 1) % 65536;
                ph = m_if.integrate ? P_CLEAR : P_IDLE;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    // Compare process: advance the model on each edge, check the DUT just after.
    always begin
        @(posedge pllclk);
        if (!reset_n) model_reset();
        else          model_advance();
        #1;
        check("capture", m_if.capture, longint'(ph == P_CAP));
        check("clear", m_if.clear, longint'(ph == P_CLEAR));
        check("latch", m_if.latch, longint'(ph == P_LATCH));
        check("frame_count", m_if.frame_count, fc);
        check("scan_done", m_if.scan_done, sdone);
        for (int a = 0; a < N; a++)
            check($sformatf("current[%0d]", a), m_if.current_a[a*LW +: LW], cur[a]);
        if (m_if.capture) cap_cnt++;
        if (m_if.clear)   clr_cnt++;
        if (m_if.latch)   lat_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge pllclk);
    endtask

    task automatic wait_latch();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge pllclk);
            if (m_if.latch) seen = 1'b1;
        end
        if (!seen) check("latch_wait_timeout", 0, 1);
    endtask

    task automatic wait_capture(input bit level, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge pllclk);
            if (m_if.capture == level) seen = 1'b1;
        end
        if (!seen) check(name, 0, 1);
    endtask

    // tx_done pulse five cycles after the latch cycle observed at this negedge.
    task automatic send_done();
        tick(5);
        m_if.tx_done = 1'b1;
        tick(1);
        m_if.tx_done = 1'b0;
    endtask

    int st  [N] = '{10, 100, 50, 70, 'hFFFFC, 1000, 2000, 3000};
    int ln  [N] = '{4, 10, 8, 8, 10, 100, 100, 100};
    int inc [N] = '{1, 3, 0, 2, 2, 7, 7, 7};
    bit sen [N] = '{1, 1, 1, 0, 1, 0, 0, 0};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_lat;
        int prev_fc, nchg, cap_w;
        bit prev_cap, done_wrap;

        m_if.enable = 1'b0; m_if.integrate = 1'b0; m_if.frame_ticks = 24'd100;
        m_if.tx_busy = 1'b0; m_if.tx_done = 1'b0;
        for (int a = 0; a < N; a++) begin
            m_if.start_a[a*LW +: LW] = LW'(st[a]);
            m_if.len_a[a*LW +: LW]   = LW'(ln[a]);
            m_if.inc_a[a*IW +: IW]   = IW'(inc[a]);
            m_if.scan_en[a]          = sen[a];
        end
        w_if.enable = 1'b0; w_if.integrate = 1'b0; w_if.frame_ticks = '0;
        w_if.tx_busy = 1'b0; w_if.tx_done = 1'b0; w_if.scan_en = '0;
        w_if.start_a = '0; w_if.len_a = '0; w_if.inc_a = '0;

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("rst_capture", m_if.capture, 0);
        check("rst_clear", m_if.clear, 0);
        check("rst_latch", m_if.latch, 0);
        check("rst_scan_done", m_if.scan_done, 0);
        check("rst_frame_count", m_if.frame_count, 0);
        check("rst_current_any", longint'(|m_if.current_a), 0);
        check("rst_wrap_preset", w_if.frame_count, 'hFFF8);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // Start latency and first full frame
        cap_cnt = 0; clr_cnt = 0; lat_cnt = 0;
        m_if.enable = 1'b1; m_if.integrate = 1'b1;
        tick(1);
        check("lat_clear_at_1", m_if.clear, 1);
        check("lat_capture_at_1", m_if.capture, 0);
        check("lat_current0_loaded", m_if.current_a[0 +: LW], 10);
        tick(1);
        check("lat_capture_at_2", m_if.capture, 1);
        check("lat_clear_at_2", m_if.clear, 0);
        wait_latch();
        check("f1_capture_cycles", cap_cnt, 100);
        check("f1_clear_pulses", clr_cnt, 1);
        check("f1_latch_pulses", lat_cnt, 1);
        send_done();
        for (int f = 2; f <= 4; f++) begin
            wait_latch();
            send_done();
        end
        tick(3);
        check("sweep_current0", m_if.current_a[0*LW +: LW], 13);
        check("sweep_current1", m_if.current_a[1*LW +: LW], 109);
        check("sweep_current2", m_if.current_a[2*LW +: LW], 50);
        check("sweep_current4_nowrap", m_if.current_a[4*LW +: LW], 'hFFFFE);
        check("sweep_scan_done", m_if.scan_done, 1);
        check("sweep_frame_count", m_if.frame_count, 4);
        check("sweep_latch_total", lat_cnt, 4);
        check("sweep_clear_total", clr_cnt, 5);

        // integrate dropped mid-frame: frame still completes
        m_if.integrate = 1'b0;
        wait_latch();
        send_done();
        tick(1);
        check("noabort_frame_count", m_if.frame_count, 5);
        check("noabort_current0_held", m_if.current_a[0 +: LW], 13);
        tick(5);
        check("noabort_idle_clears", clr_cnt, 5);

        // tx_busy delays latch; stray tx_done ignored
        m_if.frame_ticks = 24'd10;
        m_if.tx_busy = 1'b1;
        m_if.integrate = 1'b1;
        wait_capture(1'b1, "busy_capture_rise_timeout");
        tick(3);
        m_if.tx_done = 1'b1;
        tick(1);
        m_if.tx_done = 1'b0;
        wait_capture(1'b0, "busy_capture_fall_timeout");
        base_lat = lat_cnt;
        tick(5);
        m_if.tx_done = 1'b1;
        tick(1);
        m_if.tx_done = 1'b0;
        tick(14);
        check("busy_no_latch", lat_cnt - base_lat, 0);
        m_if.tx_busy = 1'b0;
        tick(1);
        check("busy_latch_first_free", m_if.latch, 1);
        m_if.integrate = 1'b0;
        send_done();
        tick(1);
        check("busy_frame_count", m_if.frame_count, 6);
        check("busy_current0_restart", m_if.current_a[0 +: LW], 11);

        // enable dropped at tick 50 of 100
        m_if.frame_ticks = 24'd100;
        m_if.integrate = 1'b1;
        base_lat = lat_cnt;
        wait_capture(1'b1, "abort_capture_rise_timeout");
        tick(50);
        m_if.enable = 1'b0;
        tick(1);
        check("abort_capture_low", m_if.capture, 0);
        tick(10);
        check("abort_no_latch", lat_cnt - base_lat, 0);
        check("abort_frame_count", m_if.frame_count, 6);
        check("abort_current0_held", m_if.current_a[0 +: LW], 10);

        // reset mid-SEND
        m_if.frame_ticks = 24'd5;
        m_if.enable = 1'b1;
        wait_latch();
        tick(2);
        #2 reset_n = 1'b0;
        #1;
        check("midsend_rst_capture", m_if.capture, 0);
        check("midsend_rst_latch", m_if.latch, 0);
        check("midsend_rst_clear", m_if.clear, 0);
        check("midsend_rst_frame_count", m_if.frame_count, 0);
        check("midsend_rst_current_any", longint'(|m_if.current_a), 0);
        @(negedge pllclk);
        reset_n = 1'b1;
        tick(1);
        check("restart_clear", m_if.clear, 1);
        check("restart_current1", m_if.current_a[1*LW +: LW], 100);
        wait_latch();
        send_done();
        tick(1);
        check("restart_frame_count", m_if.frame_count, 1);
        m_if.enable = 1'b0;

        // frame_count wrap with single-cycle capture windows
        check("wrap_start", w_if.frame_count, 'hFFF8);
        w_if.enable = 1'b1; w_if.integrate = 1'b1; w_if.tx_done = 1'b1;
        prev_fc = int'(w_if.frame_count);
        prev_cap = 1'b0; nchg = 0; cap_w = 0; done_wrap = 1'b0;
        for (int i = 0; i < 300 && !done_wrap; i++) begin
            @(negedge pllclk);
            if (w_if.capture) begin
                cap_w++;
                if (prev_cap) check("wrap_capture_width", 2, 1);
            end
            prev_cap = w_if.capture;
            if (int'(w_if.frame_count) != prev_fc) begin
                check("wrap_increment", w_if.frame_count, (prev_fc + 1) % 65536);
                prev_fc = int'(w_if.frame_count);
                nchg++;
                if (nchg == 8) begin
                    check("wrap_value", w_if.frame_count, 0);
                    check("wrap_capture_pulses", cap_w, 8);
                    done_wrap = 1'b1;
                end
            end
        end
        if (!done_wrap) check("wrap_timeout", nchg, 8);
        w_if.enable = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 8, number of correlator inputs.
REQ-002 SHALL have parameter LAG_W, default 20, lag word width per input.
REQ-003 SHALL have parameter INC_W, default 12, lag increment width per input.
REQ-004 SHALL have parameter FRAME_W, default 24, integration length counter width.
REQ-005 SHALL have ports: pllclk  in  1  sole clock, rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: enable  in  1  global run; integrate  in  1  host integration request (level).
REQ-007 SHALL have ports: frame_ticks  in  FRAME_W  integration length in pllclk cycles; scan_en  in  NUM_INPUTS  per-input lag sweep enable.
REQ-008 SHALL have ports: start_a  in  NUM_INPUTS*LAG_W; len_a  in  NUM_INPUTS*LAG_W; inc_a  in  NUM_INPUTS*INC_W (input a at slice a*W).
REQ-009 SHALL have ports: tx_busy  in  1  packet generator busy; tx_done  in  1  one-cycle packet sent pulse.
REQ-010 SHALL have ports: current_a  out  NUM_INPUTS*LAG_W  active lag per input; capture  out  1  integration window; clear  out  1  counter clear pulse; latch  out  1  payload snapshot pulse; frame_count  out  16; scan_done  out  1.

Function
REQ-011 SHALL implement FSM states IDLE, CLEAR, INTEGRATE, WAIT_TX, LATCH, SEND, STEP; all outputs registered.
REQ-012 IDLE: when enable&integrate, load current[a]=start[a] for all a, clear per-input done flags, go CLEAR next cycle.
REQ-013 CLEAR: assert clear for exactly one cycle, zero tick counter, go INTEGRATE.
REQ-014 INTEGRATE: capture=1; tick counter increments each cycle; after frame_ticks cycles of capture (frame_ticks=0 treated as 1) go WAIT_TX.
REQ-015 WAIT_TX: capture=0; go LATCH in first cycle tx_busy=0.
REQ-016 LATCH: assert latch exactly one cycle, go SEND.
REQ-017 SEND: tx_done sampled only in this state; on tx_done go STEP; tx_done in any other state ignored.
REQ-018 STEP (one cycle): per input with scan_en[a]=1 and not done: if current+inc < start+len then current+=inc else current held, done[a]=1; inputs with inc=0 or scan_en=0 are done and held.
REQ-019 STEP comparisons SHALL use LAG_W+1-bit unsigned sums; no wrap of current.
REQ-020 STEP increments frame_count, wrapping 0xFFFF->0x0000.
REQ-021 scan_done = AND of all done flags, updated in STEP, cleared on IDLE->CLEAR.
REQ-022 After STEP: if enable&integrate go CLEAR (continue, currents held once done), else IDLE.
REQ-023 integrate deasserted during CLEAR..SEND SHALL NOT abort; current frame completes through STEP.
REQ-024 enable deasserted in any state: next cycle IDLE, capture/clear/latch=0, current_a and frame_count held.
REQ-025 Latency: integrate rising in IDLE -> clear at +1 cycle, capture first high at +2.

Reset
REQ-026 On reset_n=0 asynchronously: state IDLE; capture, clear, latch, scan_done=0; frame_count=0; current_a=0; tick counter and done flags=0.
REQ-027 Reset mid-frame SHALL drop capture immediately with no latch pulse.

Structure
REQ-028 Package frame_scheduler_pkg SHALL hold the state encoding and default width constants (LAG_W, INC_W, FRAME_W, frame_count width 16).
REQ-029 Per-input step logic SHALL be one sub-module lag_stepper (holds current, done), instantiated NUM_INPUTS times in a generate loop.

Verification
REQ-030 frame_ticks=100, integrate held, tx_busy=0, tx_done 5 cycles after latch -> capture high exactly 100 cycles, one clear and one latch pulse per frame.
REQ-031 start=10, len=4, inc=1, scan_en=1 -> current 10,11,12,13 over frames; after 4th STEP scan_done=1, current holds 13.
REQ-032 tx_busy high 20 cycles after INTEGRATE -> latch delayed until first cycle tx_busy=0; stray tx_done during INTEGRATE ignored.
REQ-033 enable dropped at tick 50 of 100 -> capture low next cycle, no latch, frame_count unchanged.
REQ-034 frame_count preset path via 65536 frames with frame_ticks=0 -> frame_count wraps to 0; frame_ticks=0 gives 1-cycle capture.
REQ-035 reset_n pulsed low mid-SEND -> all outputs zero asynchronously, FSM IDLE, restart from start values.
